// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_ctrl
//  Description : Instruction-fetch sequencer between the IF stage and a
//                synchronous-read instruction memory. It owns the program
//                counter and issues at most one word address per cycle. A
//                small FIFO absorbs the memory's one-cycle read latency. It
//                also applies ID stalls, EX redirects and an optional halt on
//                an end-of-program word.
//  Ports       : clk_50         - clock, rising edge
//                rst_n          - asynchronous active-low reset
//                imem_addr      - word address to instruction memory (reg)
//                imem_inst      - read data, valid one cycle after address
//                stall_i        - ID stage cannot accept this cycle
//                redirect_i     - taken branch/jump pulse from EX
//                redirect_pc_i  - redirect target (low two bits ignored)
//                if_valid_o     - if_inst_o/if_pc_o hold a real instruction
//                if_inst_o      - instruction, NOP (32'h13) when invalid
//                if_pc_o        - PC of if_inst_o, 0 when invalid
//                halted_o       - fetch stopped on an all-zero word
//  Options     : IF_HALT_ON_ZERO_EN - when defined, a captured 32'h0 word is
//                dropped and fetch halts until a redirect or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_50,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        halted_o
);

    localparam int                PTR_W    = $clog2(BUF_DEPTH);
    localparam int                CNT_W    = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(BUF_DEPTH);
    localparam logic [31:0]       NOP_INST = 32'h0000_0013;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      pc_q,     pc_d;
    logic             req_q,    req_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_inst_q [BUF_DEPTH];
    logic [31:0]      fifo_pc_q   [BUF_DEPTH];
    logic             halted_q;

    logic             w_pop;
    logic             w_push;
    logic             w_issue;
    logic             w_zero_hit;
    logic [CNT_W:0]   w_occ;
    logic             w_unused_ok;

    // Only word addresses are fetched; the byte offset of a target is dropped.
    assign w_unused_ok = &{1'b0, redirect_pc_i[1:0]};

    // ------------------------------------------------------------------
    // Optional end-of-program halt
    // ------------------------------------------------------------------
`ifdef IF_HALT_ON_ZERO_EN
    logic halted_d;

    assign w_zero_hit = req_q && !halted_q && (imem_inst == 32'h0);

    always_comb begin
        halted_d = halted_q;
        if (redirect_i) begin
            halted_d = 1'b0;
        end else if (w_zero_hit) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
`else
    assign w_zero_hit = 1'b0;
    assign halted_q   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake and issue decisions
    // ------------------------------------------------------------------
    // A redirect discards the head, so it is never counted as consumed.
    assign w_pop  = (count_q != '0) && !stall_i && !redirect_i;

    // Once halted, any word still in flight behind the zero word is dropped.
    assign w_push = req_q && !halted_q && !w_zero_hit && !redirect_i;

    // Slots already committed after this cycle: buffered + in flight - leaving.
    assign w_occ  = {1'b0, count_q} + {{CNT_W{1'b0}}, req_q}
                  - {{CNT_W{1'b0}}, w_pop};

    assign w_issue = !redirect_i && !halted_q && (w_occ < {1'b0, DEPTH_C});

    always_comb begin
        pc_d     = pc_q;
        req_d    = 1'b0;
        req_pc_d = req_pc_q;
        count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        if (redirect_i) begin
            pc_d     = {redirect_pc_i[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (w_issue) begin
            req_d    = 1'b1;
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk_50) begin
        if (w_push) begin
            fifo_inst_q[wr_ptr_q] <= imem_inst;
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_50) begin
        if (rst_n) begin
            assert (!(w_push && !w_pop && (count_q == DEPTH_C)));
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The memory samples the candidate PC every cycle; the read result is
    // only kept when that cycle actually issued (req_q next cycle).
    assign imem_addr  = pc_q;
    assign if_valid_o = (count_q != '0);
    assign if_inst_o  = if_valid_o ? fifo_inst_q[rd_ptr_q] : NOP_INST;
    assign if_pc_o    = if_valid_o ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign halted_o   = halted_q;

endmodule
`default_nettype wire

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch sequencer between the pipeline's IF stage and the synchronous-read instruction memory. Owns the program counter, issues one word address per cycle, absorbs the memory's one-cycle read latency in a small FIFO, and applies ID-stage stalls, branch/jump redirects and end-of-program halt. The decode stage consumes `if_inst_o`/`if_pc_o` under a valid/stall handshake.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `BUF_DEPTH`, 2: fetch FIFO entries; power of two, ≥ 2.
- `clk_50` in 1: single clock, all flops rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_addr` out 32: word address to instruction memory, registered.
- `imem_inst` in 32: memory read data; word for the address driven in cycle n is valid in cycle n+1.
- `stall_i` in 1: ID stage cannot accept this cycle.
- `redirect_i` in 1: taken branch/jump from EX; one-cycle pulse.
- `redirect_pc_i` in 32: redirect target.
- `if_valid_o` out 1: `if_inst_o`/`if_pc_o` hold a real instruction.
- `if_inst_o` out 32: instruction; 32'h0000_0013 (NOP) whenever `if_valid_o`=0.
- `if_pc_o` out 32: PC of `if_inst_o`; 0 when invalid.
- `halted_o` out 1: fetch stopped on end-of-program word.

## Operation
- Registers: `pc_q`, in-flight flag `req_q` with `req_pc_q`, FIFO (inst, pc) with occupancy count, `halted_q`.
- Issue in cycle n when `!halted_q` and `count + req_q − pop < BUF_DEPTH` (pop = `if_valid_o && !stall_i`). Issue sets `req_q`/`req_pc_q` = `pc_q`, `pc_q` += 4, `imem_addr` = `pc_q`. No issue: `pc_q`, `imem_addr` hold.
- Capture: when `req_q`=1, `{imem_inst, req_pc_q}` pushes into FIFO at end of that cycle. FIFO never overflows by construction; assert if push with count=BUF_DEPTH and no pop.
- Output: FIFO head drives `if_inst_o`/`if_pc_o`; `if_valid_o` = count≠0. Pop when `!stall_i`. Simultaneous push and pop keep count.
- Redirect (highest priority, overrides stall, halt, issue): FIFO flushed (count=0), in-flight word discarded, `halted_q` cleared, `pc_q` = `{redirect_pc_i[31:2],2'b00}`, new request issued next cycle.
- `stall_i` with `redirect_i` in same cycle: redirect wins; head discarded, not popped.
- PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 → 0.
- Reset mid-operation: all state returns to reset values immediately; in-flight data ignored.

## Timing
- Reset values: `imem_addr`=`RESET_PC`, `pc_q`=`RESET_PC`, `req_q`=0, count=0, `halted_q`=0, `if_valid_o`=0, `if_inst_o`=32'h13, `if_pc_o`=0, `halted_o`=0.
- First cycle after `rst_n` rises: issue `RESET_PC`; `if_valid_o`=1 two cycles later.
- Redirect in cycle n: `imem_addr`=target in n+1, word on `imem_inst` in n+2, `if_valid_o`=1 with `if_pc_o`=target in n+3.
- Steady state, no stall: one instruction per cycle, consecutive PCs +4.
- Stall held k cycles: output stable k cycles, fetch stops once FIFO+in-flight = BUF_DEPTH; resumes at 1/cycle after release without lost or duplicated PCs.

## Configuration
- `IF_HALT_ON_ZERO_EN` defined: captured word 32'h0000_0000 is not pushed; `halted_q`=1 from next cycle; no further issue; FIFO contents ahead of it still drain; cleared only by redirect or reset.
- Undefined: zero words push as ordinary instructions, `halted_o` tied 0, fetch never self-stops.

## Test plan
- Reset release, no stall, program of NOPs at 0..16: `if_pc_o` = 0,4,8,12,16 on consecutive cycles starting 2 cycles after reset release.
- `stall_i` high 3 cycles while `if_pc_o`=20: output holds 20 with inst 32'hff810113 for 3 cycles, then 24,28 back-to-back; no PC skipped or repeated.
- `redirect_i` with target 40 while FIFO holds 52,56: both flushed, `if_valid_o` low 2 cycles, `if_pc_o`=40 exactly 3 cycles after pulse.
- Redirect to 32'h0000_0045: fetch resumes at 32'h44.
- `IF_HALT_ON_ZERO_EN` on, word 0 at 148: PCs up to 144 (32'h00a54533) delivered, `halted_o`=1, `if_valid_o`=0 afterward; redirect to 0 clears halt and refetches 0. Macro off: PC 148 delivered with inst 0.
- Assert `rst_n` low while stalled with full FIFO: outputs at reset values same cycle; refetch from `RESET_PC` after release.
